// File: rtl/seg8_pkg.sv
// ---------------------------------------------------------------------------
// seg8_pkg
// Shared constants for the tri-digit SN74HC595 seven-segment link.
// Segment bytes are common-anode: a 0 bit lights the segment. Bit 7 is the
// decimal point (active low), bits 6:0 are segments g..a.
// Contents:
//   FRAME_BITS          - shift edges per frame (3 digits x 8 bits)
//   CHAR_0 .. CHAR_9    - digit glyphs with the point off
//   CHAR_POINT          - point only
//   CHAR_ON / CHAR_OFF  - all segments lit / all dark
//   DIGIT_ILLEGAL       - digit value reported for an unrecognised glyph
// ---------------------------------------------------------------------------
package seg8_pkg;

    localparam int FRAME_BITS = 24;

    localparam logic [7:0] CHAR_0     = 8'hC0;
    localparam logic [7:0] CHAR_1     = 8'hF9;
    localparam logic [7:0] CHAR_2     = 8'hA4;
    localparam logic [7:0] CHAR_3     = 8'hB0;
    localparam logic [7:0] CHAR_4     = 8'h99;
    localparam logic [7:0] CHAR_5     = 8'h92;
    localparam logic [7:0] CHAR_6     = 8'h82;
    localparam logic [7:0] CHAR_7     = 8'hF8;
    localparam logic [7:0] CHAR_8     = 8'h80;
    localparam logic [7:0] CHAR_9     = 8'h90;
    localparam logic [7:0] CHAR_POINT = 8'h7F;
    localparam logic [7:0] CHAR_ON    = 8'h00;
    localparam logic [7:0] CHAR_OFF   = 8'hFF;

    localparam logic [3:0] DIGIT_ILLEGAL = 4'hF;

endpackage

// File: rtl/seg8_code_decoder.sv
// ---------------------------------------------------------------------------
// seg8_code_decoder
// Combinational decode of one common-anode segment byte back to BCD.
// Ports:
//   code_i    [7:0] segment byte, bit 7 = point (active low)
//   digit_o   [3:0] decoded digit, 4'hF when the glyph is not a digit
//   dp_o            point lit
//   illegal_o       glyph (bits 6:0) matches none of CHAR_0..CHAR_9
// ---------------------------------------------------------------------------
module seg8_code_decoder
    import seg8_pkg::*;
(
    input  logic [7:0] code_i,
    output logic [3:0] digit_o,
    output logic       dp_o,
    output logic       illegal_o
);

    assign dp_o = ~code_i[7];

    // Only the segment bits take part in the match; the point is independent.
    always_comb begin
        digit_o   = DIGIT_ILLEGAL;
        illegal_o = 1'b0;
        case (code_i[6:0])
            CHAR_0[6:0]: digit_o = 4'd0;
            CHAR_1[6:0]: digit_o = 4'd1;
            CHAR_2[6:0]: digit_o = 4'd2;
            CHAR_3[6:0]: digit_o = 4'd3;
            CHAR_4[6:0]: digit_o = 4'd4;
            CHAR_5[6:0]: digit_o = 4'd5;
            CHAR_6[6:0]: digit_o = 4'd6;
            CHAR_7[6:0]: digit_o = 4'd7;
            CHAR_8[6:0]: digit_o = 4'd8;
            CHAR_9[6:0]: digit_o = 4'd9;
            default:     illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/sn74hc595_trio_seg8_receiver.sv
// ---------------------------------------------------------------------------
// sn74hc595_trio_seg8_receiver
// Oversamples the 595 serial link on clk, rebuilds the 24-bit chain image and
// decodes it into three BCD digits plus the decimal-point position on every
// load rising edge.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   clk_serial   driver shift clock (data taken on its rising edge)
//   data         serial data, digit 2 MSB first
//   load         latch strobe, frame committed on its rising edge
//   num0..num2   decoded digits (4'hF for an unknown glyph)
//   point_pos    0 = no point, k = point after digit k-1
//   seg_raw      committed chain image {digit2, digit1, digit0}
//   valid        one-clock pulse when the outputs above update
//   code_err     committed frame had an unknown glyph or several points
//   frame_err    committed frame did not contain exactly FRAME_BITS shifts
// Output handshake: valid is a single-cycle strobe with no back-pressure;
// all decoded outputs change only in the cycle valid is high and then hold.
// ---------------------------------------------------------------------------
module sn74hc595_trio_seg8_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = seg8_pkg::FRAME_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_serial,
    input  logic        data,
    input  logic        load,
    output logic [3:0]  num0,
    output logic [3:0]  num1,
    output logic [3:0]  num2,
    output logic [1:0]  point_pos,
    output logic [23:0] seg_raw,
    output logic        valid,
    output logic        code_err,
    output logic        frame_err
);

    import seg8_pkg::*;

    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

    logic [SYNC_STAGES-1:0] sclk_sync_q, data_sync_q, load_sync_q;
    logic                   sclk_hist_q, load_hist_q;
    logic                   sclk_s, data_s, load_s;
    logic                   shift, commit;

    logic [23:0] sr_q, sr_d;
    logic [4:0]  cnt_q, cnt_d;

    logic [23:0] seg_raw_q;
    logic [3:0]  num0_q, num1_q, num2_q;
    logic [1:0]  point_q, point_d;
    logic        valid_q, code_err_q, frame_err_q;

    logic [3:0]  dig0, dig1, dig2;
    logic [2:0]  dp, illegal;
    logic        multi_pt;

    // Synchronizers plus one history flop per edge-detected input. data has
    // the same depth as clk_serial so it is sampled in the edge cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            data_sync_q <= '0;
            load_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            load_hist_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], clk_serial};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], data};
            load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], load};
            sclk_hist_q <= sclk_s;
            load_hist_q <= load_s;
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign load_s = load_sync_q[SYNC_STAGES-1];
    assign shift  = sclk_s & ~sclk_hist_q;
    assign commit = load_s & ~load_hist_q;

    // Shift register and saturating edge counter. A shift coinciding with a
    // commit is the first bit of the next frame, so the counter restarts at 1.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (shift) begin
            sr_d = {sr_q[22:0], data_s};
            if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
        end
        if (commit) cnt_d = shift ? 5'd1 : 5'd0;
    end

    // Decode the pre-shift image so the commit never includes a coincident bit.
    seg8_code_decoder u_dec0 (.code_i(sr_q[7:0]),   .digit_o(dig0), .dp_o(dp[0]), .illegal_o(illegal[0]));
    seg8_code_decoder u_dec1 (.code_i(sr_q[15:8]),  .digit_o(dig1), .dp_o(dp[1]), .illegal_o(illegal[1]));
    seg8_code_decoder u_dec2 (.code_i(sr_q[23:16]), .digit_o(dig2), .dp_o(dp[2]), .illegal_o(illegal[2]));

    always_comb begin
        point_d  = 2'd0;
        multi_pt = 1'b0;
        case (dp)
            3'b000:  point_d = 2'd0;
            3'b001:  point_d = 2'd1;
            3'b010:  point_d = 2'd2;
            3'b100:  point_d = 2'd3;
            default: multi_pt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q        <= '0;
            cnt_q       <= '0;
            seg_raw_q   <= '0;
            num0_q      <= '0;
            num1_q      <= '0;
            num2_q      <= '0;
            point_q     <= '0;
            valid_q     <= 1'b0;
            code_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            valid_q <= commit;
            if (commit) begin
                seg_raw_q   <= sr_q;
                num0_q      <= dig0;
                num1_q      <= dig1;
                num2_q      <= dig2;
                point_q     <= point_d;
                code_err_q  <= (|illegal) | multi_pt;
                frame_err_q <= (cnt_q != FRAME_CNT);
            end
        end
    end

    assign num0      = num0_q;
    assign num1      = num1_q;
    assign num2      = num2_q;
    assign point_pos = point_q;
    assign seg_raw   = seg_raw_q;
    assign valid     = valid_q;
    assign code_err  = code_err_q;
    assign frame_err = frame_err_q;

endmodule
